// File: rtl/store_checker_pkg.sv
// Shared types and constants for the store checker: FSM state encoding,
// default timeout and counter widths.
package store_checker_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PASS = 2'd2,
    FAIL = 2'd3
  } state_t;

  localparam int DEFAULT_TIMEOUT = 200;
  localparam int STRAY_W         = 16;
  localparam int DATA_W          = 32;

endpackage

// File: rtl/store_expect_table.sv
// Expected-store table: DEPTH entries of {address, data}, one write port and
// one combinational read port, cleared asynchronously on reset.
module store_expect_table
  import store_checker_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [$clog2(DEPTH)-1:0]   wr_idx,
  input  logic [DATA_W-1:0]          wr_adr,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic [$clog2(DEPTH)-1:0]   rd_idx,
  output logic [DATA_W-1:0]          rd_adr,
  output logic [DATA_W-1:0]          rd_data
);

  logic [2*DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_idx] <= {wr_adr, wr_data};
    end
  end

  assign {rd_adr, rd_data} = mem[rd_idx];

endmodule

// File: rtl/store_checker.sv
// Snoops the processor store port, matches stores in order against the
// expected table and declares pass, fail or timeout.
module store_checker
  import store_checker_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = DEFAULT_TIMEOUT,
  parameter bit STRICT  = 1'b0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [$clog2(DEPTH):0]     num_exp,
  input  logic                       exp_we,
  input  logic [$clog2(DEPTH)-1:0]   exp_idx,
  input  logic [DATA_W-1:0]          exp_adr,
  input  logic [DATA_W-1:0]          exp_data,
  input  logic                       memwrite,
  input  logic [DATA_W-1:0]          dataadr,
  input  logic [DATA_W-1:0]          writedata,
  output logic                       done,
  output logic                       pass,
  output logic                       timed_out,
  output logic [$clog2(DEPTH):0]     matched,
  output logic [STRAY_W-1:0]         stray,
  output logic [31:0]                cycles,
  output logic [DATA_W-1:0]          last_adr,
  output logic [DATA_W-1:0]          last_data
);

  localparam int IW = $clog2(DEPTH);
  localparam int NW = IW + 1;

  state_t            state;
  logic [NW-1:0]     exp_cnt;
  logic [DATA_W-1:0] ref_adr;
  logic [DATA_W-1:0] ref_data;
  logic [NW-1:0]     matched_nxt;
  logic              hit;
  logic              final_hit;
  logic              strict_miss;
  logic              at_limit;

  function automatic logic [NW-1:0] clamp_cnt(input logic [NW-1:0] n);
    if (n == '0) return NW'(1);
    if (n > NW'(DEPTH)) return NW'(DEPTH);
    return n;
  endfunction

  function automatic logic [STRAY_W-1:0] sat_inc(input logic [STRAY_W-1:0] v);
    if (&v) return v;
    return v + 1'b1;
  endfunction

  store_expect_table #(.DEPTH(DEPTH)) u_table (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (exp_we),
    .wr_idx  (exp_idx),
    .wr_adr  (exp_adr),
    .wr_data (exp_data),
    .rd_idx  (matched[IW-1:0]),
    .rd_adr  (ref_adr),
    .rd_data (ref_data)
  );

  // Compare stage: the table entry at the current match position
  assign hit         = memwrite && ({dataadr, writedata} == {ref_adr, ref_data});
  assign matched_nxt = matched + 1'b1;
  assign final_hit   = hit && (matched_nxt == exp_cnt);
  assign strict_miss = STRICT && memwrite && !hit;
  assign at_limit    = (cycles == 32'(TIMEOUT - 1));

  assign done = (state == PASS) || (state == FAIL);
  assign pass = (state == PASS);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      exp_cnt   <= '0;
      matched   <= '0;
      stray     <= '0;
      cycles    <= '0;
      timed_out <= 1'b0;
      last_adr  <= '0;
      last_data <= '0;
    end else if (start) begin
      state     <= RUN;
      exp_cnt   <= clamp_cnt(num_exp);
      matched   <= '0;
      stray     <= '0;
      cycles    <= '0;
      timed_out <= 1'b0;
      last_adr  <= '0;
      last_data <= '0;
    end else if (state == RUN) begin
      cycles <= cycles + 32'd1;
      if (memwrite) begin
        last_adr  <= dataadr;
        last_data <= writedata;
        if (hit) matched <= matched_nxt;
        else if (!STRICT) stray <= sat_inc(stray);
      end
      // A final match beats the timeout; a strict mismatch beats it too
      if (final_hit) begin
        state <= PASS;
      end else if (strict_miss) begin
        state <= FAIL;
      end else if (at_limit) begin
        state     <= FAIL;
        timed_out <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_store_checker.sv
// Bench for store_checker: a lenient and a strict instance share stimulus and
// are compared every cycle against a behavioural model of the checker.
module tb_store_checker;

  localparam int DEPTH = 4;
  localparam int TOUT  = 200;
  localparam int M_IDLE = 0, M_RUN = 1, M_PASSED = 2, M_FAILED = 3;

  logic        clk = 1'b0;
  logic        reset, start, exp_we, memwrite;
  logic [2:0]  num_exp;
  logic [1:0]  exp_idx;
  logic [31:0] exp_adr, exp_data, dataadr, writedata;

  logic        done_o [2];
  logic        pass_o [2];
  logic        to_o   [2];
  logic [2:0]  match_o[2];
  logic [15:0] stray_o[2];
  logic [31:0] cyc_o  [2];
  logic [31:0] la_o   [2];
  logic [31:0] ld_o   [2];

  int tests = 0;
  int fails = 0;

  // model state
  logic [31:0] tab_a [DEPTH];
  logic [31:0] tab_d [DEPTH];
  int          m_st   [2];
  int          m_match[2];
  int          m_stray[2];
  int          m_cnt  [2];
  logic [31:0] m_cyc  [2];
  bit          m_to   [2];
  logic [31:0] m_la   [2];
  logic [31:0] m_ld   [2];

  always #5 clk = ~clk;

  store_checker #(.DEPTH(DEPTH), .TIMEOUT(TOUT), .STRICT(1'b0)) dut0 (
    .clk(clk), .reset(reset), .start(start), .num_exp(num_exp),
    .exp_we(exp_we), .exp_idx(exp_idx), .exp_adr(exp_adr), .exp_data(exp_data),
    .memwrite(memwrite), .dataadr(dataadr), .writedata(writedata),
    .done(done_o[0]), .pass(pass_o[0]), .timed_out(to_o[0]), .matched(match_o[0]),
    .stray(stray_o[0]), .cycles(cyc_o[0]), .last_adr(la_o[0]), .last_data(ld_o[0])
  );

  store_checker #(.DEPTH(DEPTH), .TIMEOUT(TOUT), .STRICT(1'b1)) dut1 (
    .clk(clk), .reset(reset), .start(start), .num_exp(num_exp),
    .exp_we(exp_we), .exp_idx(exp_idx), .exp_adr(exp_adr), .exp_data(exp_data),
    .memwrite(memwrite), .dataadr(dataadr), .writedata(writedata),
    .done(done_o[1]), .pass(pass_o[1]), .timed_out(to_o[1]), .matched(match_o[1]),
    .stray(stray_o[1]), .cycles(cyc_o[1]), .last_adr(la_o[1]), .last_data(ld_o[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      tab_a[i] = '0;
      tab_d[i] = '0;
    end
    for (int s = 0; s < 2; s++) begin
      m_st[s] = M_IDLE; m_match[s] = 0; m_stray[s] = 0; m_cnt[s] = 0;
      m_cyc[s] = '0; m_to[s] = 1'b0; m_la[s] = '0; m_ld[s] = '0;
    end
  endtask

  // One rising edge of behaviour, evaluated from the inputs about to be sampled
  task automatic model_edge();
    for (int s = 0; s < 2; s++) begin
      if (start) begin
        m_st[s] = M_RUN; m_match[s] = 0; m_stray[s] = 0; m_cyc[s] = '0;
        m_to[s] = 1'b0; m_la[s] = '0; m_ld[s] = '0;
        m_cnt[s] = (num_exp == 0) ? 1 : (int'(num_exp) > DEPTH ? DEPTH : int'(num_exp));
      end else if (m_st[s] == M_RUN) begin
        bit finished = 1'b0;
        bit broke    = 1'b0;
        m_cyc[s] = m_cyc[s] + 1;
        if (memwrite) begin
          m_la[s] = dataadr;
          m_ld[s] = writedata;
          if (dataadr == tab_a[m_match[s]] && writedata == tab_d[m_match[s]]) begin
            m_match[s]++;
            if (m_match[s] == m_cnt[s]) finished = 1'b1;
          end else if (s == 1) begin
            broke = 1'b1;
          end else if (m_stray[s] < 65535) begin
            m_stray[s]++;
          end
        end
        if (finished) m_st[s] = M_PASSED;
        else if (broke) m_st[s] = M_FAILED;
        else if (m_cyc[s] == 32'(TOUT)) begin
          m_st[s] = M_FAILED;
          m_to[s] = 1'b1;
        end
      end
    end
    if (exp_we) begin
      tab_a[exp_idx] = exp_adr;
      tab_d[exp_idx] = exp_data;
    end
  endtask

  task automatic check_all(input string tag);
    for (int s = 0; s < 2; s++) begin
      chk($sformatf("%s.s%0d.done", tag, s), 32'(done_o[s]),
          32'(m_st[s] == M_PASSED || m_st[s] == M_FAILED));
      chk($sformatf("%s.s%0d.pass", tag, s), 32'(pass_o[s]), 32'(m_st[s] == M_PASSED));
      chk($sformatf("%s.s%0d.timed_out", tag, s), 32'(to_o[s]), 32'(m_to[s]));
      chk($sformatf("%s.s%0d.matched", tag, s), 32'(match_o[s]), 32'(m_match[s]));
      chk($sformatf("%s.s%0d.stray", tag, s), 32'(stray_o[s]), 32'(m_stray[s]));
      chk($sformatf("%s.s%0d.cycles", tag, s), cyc_o[s], m_cyc[s]);
      chk($sformatf("%s.s%0d.last_adr", tag, s), la_o[s], m_la[s]);
      chk($sformatf("%s.s%0d.last_data", tag, s), ld_o[s], m_ld[s]);
    end
  endtask

  task automatic tick(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic write_entry(input int idx, input logic [31:0] a, input logic [31:0] d);
    exp_we = 1'b1; exp_idx = 2'(idx); exp_adr = a; exp_data = d;
    tick("wr");
    exp_we = 1'b0;
  endtask

  task automatic do_start(input int n);
    num_exp = 3'(n); start = 1'b1;
    tick("start");
    start = 1'b0;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input string tag);
    memwrite = 1'b1; dataadr = a; writedata = d;
    tick(tag);
    memwrite = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; exp_we = 1'b0; memwrite = 1'b0; num_exp = '0;
    exp_idx = '0; exp_adr = '0; exp_data = '0; dataadr = '0; writedata = '0;
    model_reset();
    #12;
    check_all("reset");
    reset = 1'b0;

    // Basic pass
    write_entry(0, 32'd18, 32'd21);
    do_start(1);
    store(32'd4, 32'd7, "basic.s1");
    store(32'd18, 32'd21, "basic.s2");
    chk("basic.stray", 32'(stray_o[0]), 32'd1);
    chk("basic.pass", 32'(pass_o[0]), 32'd1);
    chk("basic.matched", 32'(match_o[0]), 32'd1);

    // Ordered multi-entry
    write_entry(0, 32'd84, 32'd7);
    write_entry(1, 32'h2c, 32'd9);
    do_start(2);
    store(32'h2c, 32'd9, "order.s1");
    chk("order.stray_first", 32'(stray_o[0]), 32'd1);
    store(32'd84, 32'd7, "order.s2");
    chk("order.not_done", 32'(done_o[0]), 32'd0);
    store(32'h2c, 32'd9, "order.s3");
    chk("order.pass", 32'(pass_o[0]), 32'd1);
    chk("order.matched", 32'(match_o[0]), 32'd2);

    // Strict mismatch
    write_entry(0, 32'h0ffffffc, 32'h3f8);
    do_start(1);
    store(32'h0ffffffc, 32'h3f9, "strict");
    chk("strict.done", 32'(done_o[1]), 32'd1);
    chk("strict.pass", 32'(pass_o[1]), 32'd0);
    chk("strict.timed_out", 32'(to_o[1]), 32'd0);
    chk("strict.last_data", ld_o[1], 32'h3f9);

    // Timeout with no stores
    do_start(1);
    for (int i = 0; i < TOUT; i++) tick("tmo.run");
    chk("tmo.done", 32'(done_o[0]), 32'd1);
    chk("tmo.timed_out", 32'(to_o[0]), 32'd1);
    chk("tmo.cycles", cyc_o[0], 32'd200);
    for (int i = 0; i < 50; i++) tick("tmo.hold");
    chk("tmo.hold_to", 32'(to_o[0]), 32'd1);
    chk("tmo.hold_cycles", cyc_o[0], 32'd200);

    // Final match on the timeout edge
    write_entry(0, 32'h1000, 32'hcafe);
    do_start(1);
    for (int i = 0; i < TOUT - 1; i++) tick("coll.run");
    chk("coll.cycles_pre", cyc_o[0], 32'd199);
    store(32'h1000, 32'hcafe, "coll.hit");
    chk("coll.pass", 32'(pass_o[0]), 32'd1);
    chk("coll.timed_out", 32'(to_o[0]), 32'd0);

    // Asynchronous reset mid-RUN
    write_entry(1, 32'h2000, 32'h55);
    do_start(2);
    store(32'h1000, 32'hcafe, "arst.s1");
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_all("arst");
    chk("arst.matched", 32'(match_o[0]), 32'd0);
    reset = 1'b0;

    // start together with a matching store
    write_entry(0, 32'h44, 32'h88);
    num_exp = 3'd2; start = 1'b1; memwrite = 1'b1; dataadr = 32'h44; writedata = 32'h88;
    tick("startwin");
    start = 1'b0; memwrite = 1'b0;
    chk("startwin.matched", 32'(match_o[0]), 32'd0);
    chk("startwin.done", 32'(done_o[0]), 32'd0);

    // Randomized episodes, including clamped num_exp values
    for (int ep = 0; ep < 16; ep++) begin
      for (int i = 0; i < DEPTH; i++)
        write_entry(i, $urandom_range(0, 15) << 2, $urandom_range(0, 7));
      do_start($urandom_range(0, 7));
      for (int c = 0; c < 40; c++) begin
        memwrite = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 2) != 0 && m_match[0] < DEPTH) begin
          dataadr   = tab_a[m_match[0]];
          writedata = tab_d[m_match[0]];
          if ($urandom_range(0, 3) == 0) writedata = writedata ^ (32'd1 << $urandom_range(0, 31));
        end else begin
          dataadr   = $urandom_range(0, 15) << 2;
          writedata = $urandom_range(0, 7);
        end
        start = ($urandom_range(0, 59) == 0);
        num_exp = 3'($urandom_range(0, 7));
        tick("rnd");
        start = 1'b0;
      end
      memwrite = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
